// File: rtl/gpr_write_arbiter_if.sv
// Write-back bus between the two requesters (ALU, load unit) and the GPR write arbiter.
// The master side drives the requests and stall; the slave side is the arbiter.
interface gpr_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              hold;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_dest;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_dest;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;
    logic [7:0]        pending_mask;
    logic [15:0]       write_count;

    modport master (
        output hold,
        output req0_valid, req0_dest, req0_data,
        input  req0_ready,
        output req1_valid, req1_dest, req1_data,
        input  req1_ready,
        input  reg_write_en, reg_write_dest, reg_write_data,
        input  pending_mask, write_count
    );

    modport slave (
        input  hold,
        input  req0_valid, req0_dest, req0_data,
        output req0_ready,
        input  req1_valid, req1_dest, req1_data,
        output req1_ready,
        output reg_write_en, reg_write_dest, reg_write_data,
        output pending_mask, write_count
    );
endinterface

// File: rtl/gpr_write_arbiter.sv
// Round-robin arbiter merging ALU and load write-backs onto a single registered
// register-file write port, with a pending-write mask and a saturating write counter.
module gpr_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    gpr_write_arbiter_if.slave bus
);

    logic              lastGrant_q, lastGrant_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wrDest_q, wrDest_d;
    logic [DATA_W-1:0] wrData_q, wrData_d;
    logic [15:0]       writeCount_q, writeCount_d;

    logic grantSel;
    logic grantOk;
    logic transfer;

    // When both requesters are valid the one that did not win last time is chosen;
    // otherwise whichever is valid wins. Grants are suppressed during reset and stall.
    always_comb begin
        grantSel       = 1'b0;
        grantOk        = reset && !bus.hold;
        if (bus.req0_valid && bus.req1_valid) begin
            grantSel = ~lastGrant_q;
        end else begin
            grantSel = bus.req1_valid;
        end
        bus.req0_ready = grantOk && bus.req0_valid && !grantSel;
        bus.req1_ready = grantOk && bus.req1_valid &&  grantSel;
        transfer       = bus.req0_ready || bus.req1_ready;
    end

    // Next-state: the write port only loads on a transfer, so dest/data hold otherwise.
    always_comb begin
        lastGrant_d  = lastGrant_q;
        wrEn_d       = transfer;
        wrDest_d     = wrDest_q;
        wrData_d     = wrData_q;
        writeCount_d = writeCount_q;
        if (transfer) begin
            lastGrant_d = grantSel;
            wrDest_d    = grantSel ? bus.req1_dest : bus.req0_dest;
            wrData_d    = grantSel ? bus.req1_data : bus.req0_data;
            if (writeCount_q != 16'hFFFF) begin
                writeCount_d = writeCount_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lastGrant_q  <= 1'b1;
            wrEn_q       <= 1'b0;
            wrDest_q     <= '0;
            wrData_q     <= '0;
            writeCount_q <= '0;
        end else begin
            lastGrant_q  <= lastGrant_d;
            wrEn_q       <= wrEn_d;
            wrDest_q     <= wrDest_d;
            wrData_q     <= wrData_d;
            writeCount_q <= writeCount_d;
        end
    end

    // The pending bit is exactly the presented write, decoded one-hot.
    always_comb begin
        bus.reg_write_en   = wrEn_q;
        bus.reg_write_dest = wrDest_q;
        bus.reg_write_data = wrData_q;
        bus.write_count    = writeCount_q;
        bus.pending_mask   = wrEn_q ? (8'b1 << wrDest_q) : 8'b0;
    end

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed bench for gpr_write_arbiter: expected writes are queued when a grant is
// expected and popped when the registered write port should present them.
module tb_gpr_write_arbiter;

    typedef struct packed {
        logic [2:0]  dest;
        logic [15:0] data;
    } wr_t;

    logic clk;
    logic reset;

    gpr_write_arbiter_if #(.DATA_W(16), .ADDR_W(3)) arb ();

    gpr_write_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (arb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wr_t         expQ[$];
    int          vectors;
    int          miscompares;
    logic [2:0]  lastDest;
    logic [15:0] lastData;
    logic [15:0] expCount;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Compares the registered write port against the oldest queued expectation.
    task automatic checkOutput(input string tag);
        wr_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check({tag, ".en"},   32'(arb.reg_write_en),   32'd1);
            check({tag, ".dest"}, 32'(arb.reg_write_dest), 32'(e.dest));
            check({tag, ".data"}, 32'(arb.reg_write_data), 32'(e.data));
            check({tag, ".mask"}, 32'(arb.pending_mask),   32'(8'b1 << e.dest));
            lastDest = e.dest;
            lastData = e.data;
        end else begin
            check({tag, ".en"},   32'(arb.reg_write_en),   32'd0);
            check({tag, ".dest"}, 32'(arb.reg_write_dest), 32'(lastDest));
            check({tag, ".data"}, 32'(arb.reg_write_data), 32'(lastData));
            check({tag, ".mask"}, 32'(arb.pending_mask),   32'd0);
        end
        check({tag, ".count"}, 32'(arb.write_count), 32'(expCount));
    endtask

    // One clock cycle: drive inputs, check the outputs of the previous cycle and the
    // combinational readys, then advance the model across the rising edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic hld,
                                 input logic v0, input logic [2:0] d0, input logic [15:0] x0,
                                 input logic v1, input logic [2:0] d1, input logic [15:0] x1,
                                 input logic exp0, input logic exp1);
        wr_t w;
        reset          = rst;
        arb.hold       = hld;
        arb.req0_valid = v0;
        arb.req0_dest  = d0;
        arb.req0_data  = x0;
        arb.req1_valid = v1;
        arb.req1_dest  = d1;
        arb.req1_data  = x1;
        #1;
        checkOutput(tag);
        check({tag, ".ready0"}, 32'(arb.req0_ready), 32'(exp0));
        check({tag, ".ready1"}, 32'(arb.req1_ready), 32'(exp1));
        if (exp0) begin
            w.dest = d0; w.data = x0; expQ.push_back(w);
        end else if (exp1) begin
            w.dest = d1; w.data = x1; expQ.push_back(w);
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            expQ.delete();
            lastDest = '0;
            lastData = '0;
            expCount = '0;
        end else if ((exp0 || exp1) && expCount != 16'hFFFF) begin
            expCount = expCount + 16'd1;
        end
    endtask

    initial begin
        wr_t w;
        vectors     = 0;
        miscompares = 0;
        lastDest    = '0;
        lastData    = '0;
        expCount    = '0;
        reset          = 1'b0;
        arb.hold       = 1'b0;
        arb.req0_valid = 1'b1;
        arb.req0_dest  = 3'd0;
        arb.req0_data  = 16'h0;
        arb.req1_valid = 1'b1;
        arb.req1_dest  = 3'd0;
        arb.req1_data  = 16'h0;
        @(posedge clk);
        #1;

        $display("[TB] reset with both requesters valid");
        applyStimulus("rst0", 0, 0, 1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, 0, 0);
        applyStimulus("rst1", 0, 0, 1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, 0, 0);

        $display("[TB] single request");
        applyStimulus("single",  1, 0, 1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000, 1, 0);
        applyStimulus("singleW", 1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        applyStimulus("req1only",1, 0, 0, 3'd0, 16'h0000, 1, 3'd7, 16'hBEEF, 0, 1);

        $display("[TB] sustained contention");
        applyStimulus("cont0", 1, 0, 1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 1, 0);
        applyStimulus("cont1", 1, 0, 1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 0, 1);
        applyStimulus("cont2", 1, 0, 1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 1, 0);
        applyStimulus("cont3", 1, 0, 1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 0, 1);

        $display("[TB] same-destination contention");
        applyStimulus("same0", 1, 0, 1, 3'd5, 16'h0001, 1, 3'd5, 16'h0002, 1, 0);
        applyStimulus("same1", 1, 0, 0, 3'd0, 16'h0000, 1, 3'd5, 16'h0002, 0, 1);

        $display("[TB] hold");
        applyStimulus("hold0", 1, 1, 0, 3'd0, 16'h0000, 1, 3'd6, 16'h0606, 0, 0);
        applyStimulus("hold1", 1, 1, 0, 3'd0, 16'h0000, 1, 3'd6, 16'h0606, 0, 0);
        applyStimulus("hold2", 1, 1, 0, 3'd0, 16'h0000, 1, 3'd6, 16'h0606, 0, 0);
        applyStimulus("holdRel", 1, 0, 0, 3'd0, 16'h0000, 1, 3'd6, 16'h0606, 0, 1);
        applyStimulus("holdLate", 1, 1, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        applyStimulus("idle0",   1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);

        $display("[TB] reset mid-operation");
        applyStimulus("midXfer", 1, 0, 1, 3'd2, 16'h0BAD, 0, 3'd0, 16'h0000, 1, 0);
        applyStimulus("midRst",  0, 0, 1, 3'd4, 16'h4040, 1, 3'd3, 16'h3030, 0, 0);
        applyStimulus("resume0", 1, 0, 1, 3'd4, 16'h4040, 1, 3'd3, 16'h3030, 1, 0);
        applyStimulus("resume1", 1, 0, 0, 3'd0, 16'h0000, 1, 3'd3, 16'h3030, 0, 1);
        applyStimulus("idle1",   1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);

        $display("[TB] write counter saturation");
        arb.req0_valid = 1'b1;
        arb.req0_dest  = 3'd4;
        arb.req0_data  = 16'h4444;
        arb.req1_valid = 1'b1;
        arb.req1_dest  = 3'd4;
        arb.req1_data  = 16'h4444;
        repeat (65536) begin
            @(posedge clk);
            #1;
            if (expCount != 16'hFFFF) expCount = expCount + 16'd1;
        end
        w.dest = 3'd4;
        w.data = 16'h4444;
        expQ.push_back(w);
        lastDest = 3'd4;
        lastData = 16'h4444;
        applyStimulus("sat0", 1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        applyStimulus("sat1", 1, 0, 1, 3'd1, 16'h0101, 0, 3'd0, 16'h0000, 1, 0);
        applyStimulus("sat2", 1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
        check("satFinal", 32'(arb.write_count), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
